// File: rtl/systolic_array_param_if.sv
// Operand input stream and result output stream of the systolic array.
// The slave side belongs to the array, the master side to whatever feeds it.
interface systolic_array_param_if #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 32
);
    logic [N*DW-1:0] a_in;
    logic [N*DW-1:0] b_in;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [N*AW-1:0] out_data;
    logic            out_valid;
    logic            out_last;
    logic            out_ready;
    logic            busy;

    modport master (
        output a_in, b_in, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  a_in, b_in, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/systolic_array_param.sv
// N x N output-stationary systolic multiplier, C = A * B, K set per job by the
// input stream length. Results are read out one row of C per transfer.
//
// state | meaning
// IDLE  | waiting for the first beat of a job
// LOAD  | streaming beats until in_last
// DRAIN | letting the last beat's wavefront reach PE(N-1,N-1)
// OUT   | presenting rows of C, one per out handshake
module systolic_array_param #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int AW     = 32,
    parameter bit SIGNED = 1'b1
) (
    input logic clk,
    input logic reset,
    systolic_array_param_if.slave io
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(2 * N) + 1;
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
    // Drain lasts 2N-2 cycles; the counter expires when it reads zero.
    localparam logic [CW-1:0] DRAIN_INIT = CW'((N > 1) ? 2 * N - 3 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] drain_q, drain_d;
    logic          accept;
    logic          clr;

    logic [DW-1:0] a_edge   [N];
    logic [DW-1:0] b_edge   [N];
    logic [DW-1:0] a_skew_q [N][N];
    logic [DW-1:0] a_skew_d [N][N];
    logic [DW-1:0] b_skew_q [N][N];
    logic [DW-1:0] b_skew_d [N][N];
    logic [DW-1:0] a_fwd_q  [N][N];
    logic [DW-1:0] a_fwd_d  [N][N];
    logic [DW-1:0] b_fwd_q  [N][N];
    logic [DW-1:0] b_fwd_d  [N][N];
    logic [DW-1:0] a_op     [N][N];
    logic [DW-1:0] b_op     [N][N];
    logic [AW-1:0] acc_q    [N][N];
    logic [AW-1:0] acc_d    [N][N];

    // Job sequencing: next state, drain timer and readout row
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        drain_d     = drain_q;
        io.in_ready = (state_q == IDLE) || (state_q == LOAD);
        accept      = io.in_valid && io.in_ready;
        clr         = accept && (state_q == IDLE);
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (io.in_last) begin
                        if (N == 1) begin
                            state_d = OUT;
                            row_d   = '0;
                        end else begin
                            state_d = DRAIN;
                            drain_d = DRAIN_INIT;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = OUT;
                    row_d   = '0;
                end else begin
                    drain_d = drain_q - CW'(1);
                end
            end
            OUT: begin
                if (io.out_ready) begin
                    if (row_q == ROW_LAST) begin
                        state_d = IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-gate operands at the edge, then skew and forward them across the array
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_edge[i]      = accept ? io.a_in[(N-1-i)*DW +: DW] : '0;
            b_edge[i]      = accept ? io.b_in[(N-1-i)*DW +: DW] : '0;
            a_skew_d[i][0] = a_edge[i];
            b_skew_d[i][0] = b_edge[i];
            for (int d = 1; d < N; d++) begin
                a_skew_d[i][d] = a_skew_q[i][d-1];
                b_skew_d[i][d] = b_skew_q[i][d-1];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) begin
                    a_op[i][j] = (i == 0) ? a_edge[i] : a_skew_q[i][(i > 0) ? i - 1 : 0];
                end else begin
                    a_op[i][j] = a_fwd_q[i][(j > 0) ? j - 1 : 0];
                end
                if (i == 0) begin
                    b_op[i][j] = (j == 0) ? b_edge[j] : b_skew_q[j][(j > 0) ? j - 1 : 0];
                end else begin
                    b_op[i][j] = b_fwd_q[(i > 0) ? i - 1 : 0][j];
                end
                a_fwd_d[i][j] = a_op[i][j];
                b_fwd_d[i][j] = b_op[i][j];
            end
        end
    end

    // Multiply-accumulate in every PE; clr restarts accumulation for a new job
    always_comb begin
        logic [2*DW-1:0] a_x;
        logic [2*DW-1:0] b_x;
        logic [2*DW-1:0] prod;
        logic [AW-1:0]   prod_w;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_x    = {{DW{SIGNED & a_op[i][j][DW-1]}}, a_op[i][j]};
                b_x    = {{DW{SIGNED & b_op[i][j][DW-1]}}, b_op[i][j]};
                // The true product fits in 2*DW bits, so the truncated multiply is exact.
                prod   = a_x * b_x;
                prod_w = AW'(prod);
                if (SIGNED && prod[2*DW-1]) begin
                    prod_w = prod_w | ({AW{1'b1}} << (2 * DW));
                end
                acc_d[i][j] = clr ? prod_w : acc_q[i][j] + prod_w;
            end
        end
    end

    // Status flags and the row-serial result view
    always_comb begin
        io.out_valid = (state_q == OUT);
        io.out_last  = (state_q == OUT) && (row_q == ROW_LAST);
        io.busy      = (state_q != IDLE);
        io.out_data  = '0;
        if (state_q == OUT) begin
            for (int j = 0; j < N; j++) begin
                io.out_data[(N-1-j)*AW +: AW] = acc_q[row_q][j];
            end
        end
    end

    // State, counters, pipeline and accumulators; reset clears everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            drain_q <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_skew_q[i][j] <= '0;
                    b_skew_q[i][j] <= '0;
                    a_fwd_q[i][j]  <= '0;
                    b_fwd_q[i][j]  <= '0;
                    acc_q[i][j]    <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_skew_q[i][j] <= a_skew_d[i][j];
                    b_skew_q[i][j] <= b_skew_d[i][j];
                    a_fwd_q[i][j]  <= a_fwd_d[i][j];
                    b_fwd_q[i][j]  <= b_fwd_d[i][j];
                    acc_q[i][j]    <= acc_d[i][j];
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_array_param.sv
// Bench for systolic_array_param: a signed and an unsigned instance see the same
// stimulus and are compared against a plain matrix-product model.
module tb_systolic_array_param;
    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 20;
    localparam int KMAX = 80;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    systolic_array_param_if #(.N(N), .DW(DW), .AW(AW)) bus_s ();
    systolic_array_param_if #(.N(N), .DW(DW), .AW(AW)) bus_u ();

    systolic_array_param #(.N(N), .DW(DW), .AW(AW), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .io(bus_s)
    );
    systolic_array_param #(.N(N), .DW(DW), .AW(AW), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .io(bus_u)
    );

    int checks   = 0;
    int failures = 0;
    int k_len    = 1;
    logic [DW-1:0] a_m [N][KMAX];
    logic [DW-1:0] b_m [KMAX][N];

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row r of A*B, each element reduced modulo 2^AW
    function automatic logic [N*AW-1:0] model_row(int r, bit sgn);
        logic [N*AW-1:0] v;
        longint s, x, y;
        v = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < k_len; k++) begin
                x = sgn ? longint'($signed(a_m[r][k])) : longint'(a_m[r][k]);
                y = sgn ? longint'($signed(b_m[k][j])) : longint'(b_m[k][j]);
                s += x * y;
            end
            v[(N-1-j)*AW +: AW] = s[AW-1:0];
        end
        return v;
    endfunction

    task automatic set_in(logic v, logic last, int k);
        logic [N*DW-1:0] av, bv;
        for (int i = 0; i < N; i++) begin
            av[(N-1-i)*DW +: DW] = v ? a_m[i][k] : DW'($urandom_range(0, 255));
            bv[(N-1-i)*DW +: DW] = v ? b_m[k][i] : DW'($urandom_range(0, 255));
        end
        bus_s.a_in = av;  bus_u.a_in = av;
        bus_s.b_in = bv;  bus_u.b_in = bv;
        bus_s.in_valid = v;    bus_u.in_valid = v;
        bus_s.in_last  = last; bus_u.in_last  = last;
    endtask

    task automatic set_ready(logic rdy);
        bus_s.out_ready = rdy;
        bus_u.out_ready = rdy;
    endtask

    task automatic load_identity();
        k_len = N;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                a_m[i][k] = (i == k) ? 8'd1 : 8'd0;
                b_m[k][i] = DW'(4 * k + i + 1);
            end
    endtask

    task automatic load_const(int kk, logic [DW-1:0] av, logic [DW-1:0] bv);
        k_len = kk;
        for (int k = 0; k < kk; k++)
            for (int i = 0; i < N; i++) begin
                a_m[i][k] = av;
                b_m[k][i] = bv;
            end
    endtask

    task automatic load_random(int kk);
        k_len = kk;
        for (int k = 0; k < kk; k++)
            for (int i = 0; i < N; i++) begin
                a_m[i][k] = DW'($urandom_range(0, 255));
                b_m[k][i] = DW'($urandom_range(0, 255));
            end
    endtask

    // Stream the current job, inserting gap_total idle cycles at random between beats
    task automatic send_beats(int gap_total);
        int gaps [KMAX];
        for (int k = 0; k < KMAX; k++) gaps[k] = 0;
        if (k_len > 1)
            for (int g = 0; g < gap_total; g++) gaps[$urandom_range(1, k_len - 1)]++;
        for (int k = 0; k < k_len; k++) begin
            repeat (gaps[k]) begin
                set_in(1'b0, 1'b0, 0);
                @(negedge clk);
            end
            set_in(1'b1, k == k_len - 1, k);
            @(negedge clk);
        end
        set_in(1'b0, 1'b0, 0);
    endtask

    // Called in the cycle after the last beat; measures cycles until out_valid
    task automatic wait_out(string tag);
        int m;
        m = 1;
        check({tag, " in_ready_drain"}, bus_s.in_ready, 1'b0);
        check({tag, " busy_drain"}, bus_s.busy, 1'b1);
        while (bus_s.out_valid !== 1'b1 && m < 200) begin
            @(negedge clk);
            m++;
        end
        check({tag, " latency"}, m, 2 * N - 1);
        check({tag, " u_valid"}, bus_u.out_valid, 1'b1);
    endtask

    task automatic read_rows(string tag, int stall_row, int stall_n);
        set_ready(1'b1);
        for (int r = 0; r < N; r++) begin
            if (r == stall_row && stall_n > 0) begin
                set_ready(1'b0);
                repeat (stall_n) begin
                    @(negedge clk);
                    check($sformatf("%s hold_s r%0d", tag, r), bus_s.out_data, model_row(r, 1'b1));
                    check($sformatf("%s hold_v r%0d", tag, r), bus_s.out_valid, 1'b1);
                end
                set_ready(1'b1);
            end
            check($sformatf("%s row_s r%0d", tag, r), bus_s.out_data, model_row(r, 1'b1));
            check($sformatf("%s row_u r%0d", tag, r), bus_u.out_data, model_row(r, 1'b0));
            check($sformatf("%s last r%0d", tag, r), bus_s.out_last, r == N - 1);
            @(negedge clk);
        end
        check({tag, " busy_end"}, bus_s.busy, 1'b0);
        check({tag, " in_ready_end"}, bus_s.in_ready, 1'b1);
        check({tag, " valid_end"}, bus_u.out_valid, 1'b0);
    endtask

    task automatic run_job(string tag, int gaps, int stall_row, int stall_n);
        send_beats(gaps);
        wait_out(tag);
        read_rows(tag, stall_row, stall_n);
    endtask

    task automatic check_idle(string tag);
        check({tag, " valid"}, bus_s.out_valid, 1'b0);
        check({tag, " last"}, bus_s.out_last, 1'b0);
        check({tag, " busy"}, bus_s.busy, 1'b0);
        check({tag, " busy_u"}, bus_u.busy, 1'b0);
        check({tag, " in_ready"}, bus_s.in_ready, 1'b1);
        check({tag, " data_s"}, bus_s.out_data, '0);
        check({tag, " data_u"}, bus_u.out_data, '0);
    endtask

    initial begin
        set_in(1'b0, 1'b0, 0);
        set_ready(1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        load_identity();
        run_job("ident", 0, -1, 0);

        // Starts in the cycle right after out_last; K=1 goes straight to DRAIN
        k_len = 1;
        for (int i = 0; i < N; i++) begin
            a_m[i][0] = DW'(i + 1);
            b_m[0][i] = 8'd1;
        end
        run_job("outer", 0, -1, 0);

        load_identity();
        run_job("ident_bub", 3, 1, 5);

        load_const(40, 8'h80, 8'h7f);
        run_job("neg_k40", 0, -1, 0);
        load_const(70, 8'h80, 8'h7f);
        run_job("wrap_k70", 0, 2, 2);
        load_const(4, 8'hff, 8'hff);
        run_job("ff_k4", 0, -1, 0);

        // Back-to-back after large accumulators: clr must discard them
        load_identity();
        run_job("ident_b2b", 0, -1, 0);

        for (int n = 0; n < 6; n++) begin
            load_random($urandom_range(1, 8));
            run_job($sformatf("rand%0d", n), $urandom_range(0, 3),
                    $urandom_range(0, N - 1), $urandom_range(0, 3));
        end

        // Reset during DRAIN
        load_identity();
        send_beats(0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_idle("rst_drain");
        repeat (10) @(negedge clk);
        check_idle("rst_drain_quiet");
        load_identity();
        run_job("after_rst_drain", 0, -1, 0);

        // Reset on row 2 of readout, with out_ready high at the same edge
        load_const(3, 8'h11, 8'h22);
        send_beats(0);
        wait_out("pre_rst_out");
        set_ready(1'b1);
        repeat (2) @(negedge clk);
        check("rst_out row2", bus_s.out_data, model_row(2, 1'b1));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_idle("rst_out");
        load_identity();
        run_job("after_rst_out", 0, 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
